// File: rtl/cpu_sequencer.sv
// cpu_sequencer: instruction register, per-opcode step counter and M-cycle
// timing for the microcode decoder. It also evaluates branch conditions.
// Optional feature: define SEQ_CB_PREFIX_EN so that cb_prefix marks the
// instruction that follows a CB prefix opcode.
module cpu_sequencer #(
  parameter int         T_PER_M      = 4,
  parameter logic [7:0] RESET_OPCODE = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mem_wait,
  input  logic       done,
  input  logic       is_cond,
  input  logic [2:0] next_cond,
  input  logic       flag_z,
  input  logic       flag_c,
  input  logic [7:0] db_in,
  output logic [7:0] opcode,
  output logic [2:0] step,
  output logic [2:0] t_phase,
  output logic       m_end,
  output logic       cc_met,
  output logic       cb_prefix,
  output logic       seq_fault
);

  localparam logic [2:0] T_LAST   = 3'(T_PER_M - 1);
  localparam logic [2:0] STEP_MAX = 3'd7;

  // What happens to IR/step at a commit; CMT_NONE away from m_end.
  typedef enum logic [1:0] {
    CMT_NONE,
    CMT_FETCH,
    CMT_FAULT,
    CMT_STEP
  } commit_e;

  commit_e    commit;
  logic [2:0] step_next;

  // A commit occurs on the last T-phase unless the bus is stalling.
  assign m_end = (t_phase == T_LAST) && !mem_wait;

  // The branch condition is selected by opcode[4:3]: NZ, Z, NC, C.
  always_comb begin
    cc_met = 1'b0;
    case (opcode[4:3])
      2'd0:    cc_met = !flag_z;
      2'd1:    cc_met = flag_z;
      2'd2:    cc_met = !flag_c;
      default: cc_met = flag_c;
    endcase
  end

  // Choose the commit action. done wins, then step overflow, then branching.
  always_comb begin
    commit    = CMT_NONE;
    step_next = step;
    if (m_end) begin
      if (done) begin
        commit    = CMT_FETCH;
        step_next = '0;
      end else if (step == STEP_MAX) begin
        commit    = CMT_FAULT;
        step_next = '0;
      end else begin
        commit    = CMT_STEP;
        step_next = (is_cond && !cc_met) ? next_cond : step + 3'd1;
      end
    end
  end

  // The T-phase counter wraps after the last phase and holds there while mem_wait is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      t_phase <= '0;
    end else if (t_phase < T_LAST) begin
      t_phase <= t_phase + 3'd1;
    end else if (!mem_wait) begin
      t_phase <= '0;
    end
  end

  // IR, step and the sticky fault flag change only on a commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      opcode    <= RESET_OPCODE;
      step      <= '0;
      seq_fault <= 1'b0;
    end else begin
      step <= step_next;
      case (commit)
        CMT_FETCH: opcode <= db_in;
        CMT_FAULT: begin
          opcode    <= RESET_OPCODE;
          seq_fault <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SEQ_CB_PREFIX_EN
  localparam logic [7:0] CB_OPCODE = 8'hCB;

  // cb_prefix is set for the instruction that follows an unprefixed CB and cleared on every other fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      cb_prefix <= 1'b0;
    end else if (commit == CMT_FETCH) begin
      cb_prefix <= (opcode == CB_OPCODE) && !cb_prefix;
    end else if (commit == CMT_FAULT) begin
      cb_prefix <= 1'b0;
    end
  end
`else
  assign cb_prefix = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: scoreboard bench for cpu_sequencer. A stimulus process
// drives one M-cycle at a time and queues the expected state for each M-cycle.
// A monitor process checks the DUT against the head of that queue on every clk.
module tb_cpu_sequencer;

  localparam int         T_PER_M  = 4;
  localparam logic [7:0] RESET_OP = 8'h00;
`ifdef SEQ_CB_PREFIX_EN
  localparam bit CB_EN = 1'b1;
`else
  localparam bit CB_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_wait;
  logic       done;
  logic       is_cond;
  logic [2:0] next_cond;
  logic       flag_z;
  logic       flag_c;
  logic [7:0] db_in;
  logic [7:0] opcode;
  logic [2:0] step;
  logic [2:0] t_phase;
  logic       m_end;
  logic       cc_met;
  logic       cb_prefix;
  logic       seq_fault;

  cpu_sequencer #(.T_PER_M(T_PER_M), .RESET_OPCODE(RESET_OP)) dut (
    .clk(clk), .rst(rst), .mem_wait(mem_wait), .done(done), .is_cond(is_cond),
    .next_cond(next_cond), .flag_z(flag_z), .flag_c(flag_c), .db_in(db_in),
    .opcode(opcode), .step(step), .t_phase(t_phase), .m_end(m_end),
    .cc_met(cc_met), .cb_prefix(cb_prefix), .seq_fault(seq_fault)
  );

  always #5 clk = ~clk;

  // Expected DUT state for one M-cycle. len is the M-cycle length in clks.
  typedef struct {
    logic [7:0] op;
    logic [2:0] step;
    logic       fault;
    logic       cb;
    logic       cc;
    int         len;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  // Reference model of the architectural state.
  logic [7:0] m_op;
  logic [2:0] m_step;
  logic       m_fault;
  logic       m_cb;

  int   mon_cyc;
  exp_t mon_e;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one full M-cycle. Decoder inputs are garbage except on the commit clk.
  task automatic applyStimulus(input logic d, input logic ic, input logic [2:0] nc,
                               input logic z, input logic c, input logic [7:0] db,
                               input int stall);
    exp_t e;
    bit   cv[4];
    logic cc;
    int   len;
    len = T_PER_M + stall;
    cv = '{!z, z, !c, c};
    cc = cv[m_op[4:3]];
    e.op = m_op; e.step = m_step; e.fault = m_fault; e.cb = m_cb; e.cc = cc; e.len = len;
    sb.push_back(e);
    flag_z = z;
    flag_c = c;
    for (int k = 0; k < len; k++) begin
      if (k == len - 1) begin
        done = d; is_cond = ic; next_cond = nc; db_in = db; mem_wait = 1'b0;
      end else begin
        done      = 1'($urandom);
        is_cond   = 1'($urandom);
        next_cond = 3'($urandom);
        db_in     = 8'($urandom);
        mem_wait  = (k < T_PER_M - 1) ? 1'($urandom) : 1'b1;
      end
      @(negedge clk);
    end
    if (d) begin
      m_cb   = CB_EN && (m_op == 8'hCB) && !m_cb;
      m_op   = db;
      m_step = 3'd0;
    end else if (m_step == 3'd7) begin
      m_step  = 3'd0;
      m_op    = RESET_OP;
      m_fault = 1'b1;
      m_cb    = 1'b0;
    end else if (ic && !cc) begin
      m_step = nc;
    end else begin
      m_step = m_step + 3'd1;
    end
  endtask

  task automatic doFetch(input logic [7:0] db);
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, db, 0);
  endtask

  task automatic doStep(input logic ic, input logic [2:0] nc, input logic z, input logic c);
    applyStimulus(1'b0, ic, nc, z, c, 8'h00, 0);
  endtask

  // Hold reset for two clks, check the reset state and release reset.
  task automatic doReset();
    sb.delete();
    rst = 1'b1;
    done = 1'b0; is_cond = 1'b0; mem_wait = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("rst_opcode", opcode, RESET_OP);
    checkOutput("rst_step", 8'(step), 8'd0);
    checkOutput("rst_t_phase", 8'(t_phase), 8'd0);
    checkOutput("rst_cb_prefix", 8'(cb_prefix), 8'd0);
    checkOutput("rst_seq_fault", 8'(seq_fault), 8'd0);
    checkOutput("rst_m_end", 8'(m_end), 8'd0);
    @(negedge clk);
    rst = 1'b0;
    m_op = RESET_OP; m_step = 3'd0; m_fault = 1'b0; m_cb = 1'b0;
  endtask

  // Monitor: compare every clk against the head expectation and pop it at its commit clk.
  initial begin
    mon_cyc = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rst === 1'b1) begin
        mon_cyc = 0;
      end else if (sb.size() > 0) begin
        mon_e = sb[0];
        checkOutput("opcode", opcode, mon_e.op);
        checkOutput("step", 8'(step), 8'(mon_e.step));
        checkOutput("seq_fault", 8'(seq_fault), 8'(mon_e.fault));
        checkOutput("cb_prefix", 8'(cb_prefix), 8'(mon_e.cb));
        checkOutput("cc_met", 8'(cc_met), 8'(mon_e.cc));
        checkOutput("t_phase", 8'(t_phase),
                    (mon_cyc < T_PER_M - 1) ? 8'(mon_cyc) : 8'(T_PER_M - 1));
        checkOutput("m_end", 8'(m_end), 8'(mon_cyc == mon_e.len - 1));
        if (mon_cyc == mon_e.len - 1) begin
          void'(sb.pop_front());
          mon_cyc = 0;
        end else begin
          mon_cyc++;
        end
      end
    end
  end

  // Stimulus: directed scenarios first, then a randomized run.
  initial begin
    rst = 1'b1; mem_wait = 1'b0; done = 1'b0; is_cond = 1'b0; next_cond = 3'd0;
    flag_z = 1'b0; flag_c = 1'b0; db_in = 8'h00;
    m_op = RESET_OP; m_step = 3'd0; m_fault = 1'b0; m_cb = 1'b0;

    doReset();
    repeat (3) doFetch(8'h00);

    doStep(1'b0, 3'd0, 1'b0, 1'b0);
    doStep(1'b0, 3'd0, 1'b0, 1'b0);
    doFetch(8'h3E);

    doFetch(8'h20);
    doStep(1'b0, 3'd0, 1'b1, 1'b0);
    doStep(1'b1, 3'd4, 1'b1, 1'b0);
    doFetch(8'h20);
    doStep(1'b0, 3'd0, 1'b0, 1'b0);
    doStep(1'b1, 3'd4, 1'b0, 1'b0);
    doFetch(8'h38);
    doStep(1'b0, 3'd0, 1'b0, 1'b1);
    doStep(1'b1, 3'd4, 1'b0, 1'b1);
    doStep(1'b1, 3'd3, 1'b0, 1'b0);
    doStep(1'b1, 3'd3, 1'b0, 1'b0);

    applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 3);
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 3);

    repeat (8) doStep(1'b0, 3'd0, 1'b0, 1'b0);
    doFetch(8'h12);
    doStep(1'b0, 3'd0, 1'b0, 1'b0);
    doStep(1'b0, 3'd0, 1'b0, 1'b0);
    mem_wait = 1'b0; done = 1'b0; is_cond = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("pre_rst_step", 8'(step), 8'(m_step));
    checkOutput("pre_rst_t_phase", 8'(t_phase), 8'd1);
    checkOutput("pre_rst_fault", 8'(seq_fault), 8'(m_fault));
    doReset();

    doFetch(8'hCB);
    doFetch(8'h7C);
    doFetch(8'hCB);
    doFetch(8'hCB);
    doFetch(8'h00);
    doFetch(8'hCB);
    repeat (8) doStep(1'b0, 3'd0, 1'b0, 1'b0);
    doFetch(8'h00);

    doReset();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        doReset();
      end else begin
        applyStimulus(1'($urandom_range(0, 3) == 0), 1'($urandom), 3'($urandom),
                      1'($urandom), 1'($urandom),
                      ($urandom_range(0, 3) == 0) ? 8'hCB : 8'($urandom),
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
      end
    end

    @(negedge clk);
    #1;
    checkOutput("scoreboard_drained", 8'(sb.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
